// File: rtl/mem_agu_dispatch.sv
// -----------------------------------------------------------------------------
// mem_agu_dispatch
//
// Purpose:
//   Collects memory micro-ops from several reservation-station issue ports,
//   grants at most one per cycle by round robin, and computes the effective
//   address one cycle later (base + imm, wrapped and truncated to ADDR_W). The
//   result is then pushed into a small in-order request FIFO whose head is
//   presented to the load/store queue. Admission is credit based: a port is
//   only granted when the FIFO, the address stage and a possible pop in the
//   same cycle still leave room for the new request. Because of this, the FIFO
//   can never overflow.
//
// Ports:
//   clk            in   clock, rising edge
//   reset          in   asynchronous, active-high reset
//   flush          in   synchronous clear of the address stage and FIFO
//   rs_valid       in   [NUM_PORTS]          per-port request valid
//   rs_ready       out  [NUM_PORTS]          per-port accept, one-hot or zero
//   rs_tag         in   [NUM_PORTS*TAG_W]    per-port ROB tag
//   rs_base        in   [NUM_PORTS*DATA_W]   per-port base register value
//   rs_imm         in   [NUM_PORTS*DATA_W]   per-port sign-extended immediate
//   rs_st_data     in   [NUM_PORTS*DATA_W]   per-port store data
//   rs_size        in   [NUM_PORTS*2]        0 byte, 1 half, 2 word, 3 = word
//   lsq_valid      out  FIFO head valid
//   lsq_ready      in   LSQ accepts the head
//   lsq_tag        out  [TAG_W]   head tag
//   lsq_data       out  [DATA_W]  head store data
//   lsq_addr       out  [ADDR_W]  head effective address
//   lsq_size       out  [2]       head access size
//   lsq_misaligned out  head misaligned for its size
//
// Configuration:
//   MEM_AGU_MISALIGN_CHECK_EN  when defined, the address stage flags half
//   accesses on odd addresses and word accesses not 4-byte aligned. The flag
//   is carried through the FIFO. When the macro is not defined, lsq_misaligned
//   is tied low and the FIFO has no flag bit.
// -----------------------------------------------------------------------------

// Invariant checker kept apart from the datapath.
module mem_agu_dispatch_chk #(
    parameter int NUM_PORTS = 2,
    parameter int BUF_DEPTH = 4,
    parameter int CNT_W     = 3
) (
    input logic                 clk,
    input logic                 reset,
    input logic [NUM_PORTS-1:0] rs_ready,
    input logic                 push,
    input logic [CNT_W-1:0]     count
);
    // Credit admission must make a push into a full FIFO impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && (count == CNT_W'(BUF_DEPTH))));

    // At most one port is granted per cycle.
    a_grant_onehot: assert property (@(posedge clk) disable iff (reset)
        $onehot0(rs_ready));
endmodule

module mem_agu_dispatch #(
    parameter int NUM_PORTS = 2,
    parameter int TAG_W     = 5,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 16,
    parameter int BUF_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic [NUM_PORTS-1:0]          rs_valid,
    output logic [NUM_PORTS-1:0]          rs_ready,
    input  logic [NUM_PORTS*TAG_W-1:0]    rs_tag,
    input  logic [NUM_PORTS*DATA_W-1:0]   rs_base,
    input  logic [NUM_PORTS*DATA_W-1:0]   rs_imm,
    input  logic [NUM_PORTS*DATA_W-1:0]   rs_st_data,
    input  logic [NUM_PORTS*2-1:0]        rs_size,
    output logic                          lsq_valid,
    input  logic                          lsq_ready,
    output logic [TAG_W-1:0]              lsq_tag,
    output logic [DATA_W-1:0]             lsq_data,
    output logic [ADDR_W-1:0]             lsq_addr,
    output logic [1:0]                    lsq_size,
    output logic                          lsq_misaligned
);
    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int IDX_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam int USE_W = CNT_W + 1;

`ifdef MEM_AGU_MISALIGN_CHECK_EN
    // Alignment rule: bytes always aligned, halves need an even address,
    // words (and the reserved size) need a 4-byte aligned address.
    function automatic logic misalign_f(input logic [1:0] size, input logic [1:0] low);
        logic bad;
        case (size)
            2'd0:    bad = 1'b0;
            2'd1:    bad = low[0];
            default: bad = (low != 2'b00);
        endcase
        return bad;
    endfunction
`endif

    // Arbitration / admission
    logic [PTR_W-1:0]  rr_ptr_r;
    logic [PTR_W-1:0]  grant_idx_s;
    logic              found_s;
    int                idx_s;
    logic [USE_W-1:0]  used_s;
    logic              credit_ok_s;
    logic [NUM_PORTS-1:0] rs_ready_s;
    logic              transfer_s;

    // Stage 1 (captured request)
    logic              s1_valid_r;
    logic [TAG_W-1:0]  s1_tag_r;
    logic [DATA_W-1:0] s1_base_r;
    logic [DATA_W-1:0] s1_imm_r;
    logic [DATA_W-1:0] s1_data_r;
    logic [1:0]        s1_size_r;

    // Stage 2 (address generation, feeds the FIFO)
    logic [ADDR_W-1:0] addr_s;
    logic              push_s;
    logic              pop_s;

    // Request FIFO
    logic [TAG_W-1:0]  fifo_tag_r  [BUF_DEPTH];
    logic [DATA_W-1:0] fifo_data_r [BUF_DEPTH];
    logic [ADDR_W-1:0] fifo_addr_r [BUF_DEPTH];
    logic [1:0]        fifo_size_r [BUF_DEPTH];
    logic [IDX_W-1:0]  wr_ptr_r;
    logic [IDX_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;

`ifdef MEM_AGU_MISALIGN_CHECK_EN
    logic              mis_s;
    logic              fifo_mis_r [BUF_DEPTH];
`endif

    // Round-robin search: first valid port at or after rr_ptr wins
    always_comb begin
        found_s     = 1'b0;
        grant_idx_s = '0;
        idx_s       = 0;
        for (int off = 0; off < NUM_PORTS; off++) begin
            idx_s       = (int'(rr_ptr_r) + off) % NUM_PORTS;
            grant_idx_s = (!found_s && rs_valid[idx_s]) ? PTR_W'(idx_s) : grant_idx_s;
            found_s     = found_s | rs_valid[idx_s];
        end
    end

    // Credit check and grant; a pop this cycle frees its slot for the new request
    always_comb begin
        pop_s       = (count_r != '0) && lsq_ready && !flush;
        push_s      = s1_valid_r && !flush;
        used_s      = {1'b0, count_r} + {{CNT_W{1'b0}}, s1_valid_r} - {{CNT_W{1'b0}}, pop_s};
        credit_ok_s = (used_s < USE_W'(BUF_DEPTH));
        rs_ready_s  = '0;
        if (!reset && !flush && credit_ok_s && found_s) begin
            rs_ready_s[grant_idx_s] = 1'b1;
        end else begin
            rs_ready_s = '0;
        end
        transfer_s = (rs_ready_s != '0);
    end

    assign rs_ready = rs_ready_s;

    // Round-robin pointer advances past the granted port; holds otherwise
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_r <= '0;
        end else if (transfer_s) begin
            rr_ptr_r <= PTR_W'((int'(grant_idx_s) + 1) % NUM_PORTS);
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Stage 1 valid: set by a transfer, otherwise cleared (flush blocks transfers)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= transfer_s && !flush;
        end
    end

    // Stage 1 payload captured from the granted port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_tag_r  <= '0;
            s1_base_r <= '0;
            s1_imm_r  <= '0;
            s1_data_r <= '0;
            s1_size_r <= 2'b00;
        end else if (transfer_s) begin
            s1_tag_r  <= rs_tag[grant_idx_s*TAG_W +: TAG_W];
            s1_base_r <= rs_base[grant_idx_s*DATA_W +: DATA_W];
            s1_imm_r  <= rs_imm[grant_idx_s*DATA_W +: DATA_W];
            s1_data_r <= rs_st_data[grant_idx_s*DATA_W +: DATA_W];
            s1_size_r <= rs_size[grant_idx_s*2 +: 2];
        end else begin
            s1_tag_r  <= s1_tag_r;
            s1_base_r <= s1_base_r;
            s1_imm_r  <= s1_imm_r;
            s1_data_r <= s1_data_r;
            s1_size_r <= s1_size_r;
        end
    end

    // Stage 2: the DATA_W-bit sum wraps naturally, then the low ADDR_W bits are kept
    always_comb begin
        addr_s = ADDR_W'(s1_base_r + s1_imm_r);
`ifdef MEM_AGU_MISALIGN_CHECK_EN
        mis_s  = misalign_f(s1_size_r, addr_s[1:0]);
`endif
    end

    // FIFO storage, written at the tail on push (contents behind count are don't-care)
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_tag_r[wr_ptr_r]  <= s1_tag_r;
            fifo_data_r[wr_ptr_r] <= s1_data_r;
            fifo_addr_r[wr_ptr_r] <= addr_s;
            fifo_size_r[wr_ptr_r] <= s1_size_r;
`ifdef MEM_AGU_MISALIGN_CHECK_EN
            fifo_mis_r[wr_ptr_r]  <= mis_s;
`endif
        end
    end

    // FIFO pointers and occupancy; power-of-two depth lets pointers wrap naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    wr_ptr_r <= wr_ptr_r + IDX_W'(1);
                    count_r  <= count_r + CNT_W'(1);
                end
                2'b01: begin
                    rd_ptr_r <= rd_ptr_r + IDX_W'(1);
                    count_r  <= count_r - CNT_W'(1);
                end
                2'b11: begin
                    wr_ptr_r <= wr_ptr_r + IDX_W'(1);
                    rd_ptr_r <= rd_ptr_r + IDX_W'(1);
                end
                default: begin
                    wr_ptr_r <= wr_ptr_r;
                    rd_ptr_r <= rd_ptr_r;
                    count_r  <= count_r;
                end
            endcase
        end
    end

    // Head presentation; fields read as zero while the FIFO is empty
    always_comb begin
        lsq_valid = (count_r != '0);
        if (lsq_valid) begin
            lsq_tag  = fifo_tag_r[rd_ptr_r];
            lsq_data = fifo_data_r[rd_ptr_r];
            lsq_addr = fifo_addr_r[rd_ptr_r];
            lsq_size = fifo_size_r[rd_ptr_r];
        end else begin
            lsq_tag  = '0;
            lsq_data = '0;
            lsq_addr = '0;
            lsq_size = 2'b00;
        end
    end

`ifdef MEM_AGU_MISALIGN_CHECK_EN
    assign lsq_misaligned = lsq_valid ? fifo_mis_r[rd_ptr_r] : 1'b0;
`else
    assign lsq_misaligned = 1'b0;
`endif

    mem_agu_dispatch_chk #(
        .NUM_PORTS (NUM_PORTS),
        .BUF_DEPTH (BUF_DEPTH),
        .CNT_W     (CNT_W)
    ) u_chk (
        .clk      (clk),
        .reset    (reset),
        .rs_ready (rs_ready_s),
        .push     (push_s),
        .count    (count_r)
    );

endmodule

// File: tb/tb_mem_agu_dispatch.sv
// Self-checking bench for mem_agu_dispatch: directed scenarios plus randomized
// traffic, all compared against a queue-based reference model.
module tb_mem_agu_dispatch;
    localparam int NP    = 2;
    localparam int TW    = 5;
    localparam int DW    = 32;
    localparam int AW    = 16;
    localparam int DEPTH = 4;
`ifdef MEM_AGU_MISALIGN_CHECK_EN
    localparam bit MIS_ON = 1'b1;
`else
    localparam bit MIS_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic [NP-1:0]    rs_valid;
    logic [NP-1:0]    rs_ready;
    logic [NP*TW-1:0] rs_tag;
    logic [NP*DW-1:0] rs_base;
    logic [NP*DW-1:0] rs_imm;
    logic [NP*DW-1:0] rs_st_data;
    logic [NP*2-1:0]  rs_size;
    logic             lsq_valid;
    logic             lsq_ready;
    logic [TW-1:0]    lsq_tag;
    logic [DW-1:0]    lsq_data;
    logic [AW-1:0]    lsq_addr;
    logic [1:0]       lsq_size;
    logic             lsq_misaligned;

    mem_agu_dispatch #(
        .NUM_PORTS(NP), .TAG_W(TW), .DATA_W(DW), .ADDR_W(AW), .BUF_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .rs_valid(rs_valid), .rs_ready(rs_ready), .rs_tag(rs_tag),
        .rs_base(rs_base), .rs_imm(rs_imm), .rs_st_data(rs_st_data),
        .rs_size(rs_size), .lsq_valid(lsq_valid), .lsq_ready(lsq_ready),
        .lsq_tag(lsq_tag), .lsq_data(lsq_data), .lsq_addr(lsq_addr),
        .lsq_size(lsq_size), .lsq_misaligned(lsq_misaligned)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
        logic [AW-1:0] addr;
        logic [1:0]    size;
        logic          mis;
    } ent_t;

    ent_t q[$];     // requests already in the output buffer, head first
    ent_t s1_m;     // request one cycle after acceptance
    bit   s1_v;
    int   rr;

    function automatic logic exp_mis(input logic [1:0] size, input logic [AW-1:0] a);
        if (!MIS_ON) return 1'b0;
        if (size == 2'd1) return (a % 2) != 0;
        if (size >= 2'd2) return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic ent_t build(input int p);
        ent_t e;
        logic [63:0] sum;
        sum    = {32'd0, rs_base[p*DW +: DW]} + {32'd0, rs_imm[p*DW +: DW]};
        sum    = sum % 64'h1_0000_0000;
        sum    = sum % (64'd1 << AW);
        e.tag  = rs_tag[p*TW +: TW];
        e.data = rs_st_data[p*DW +: DW];
        e.addr = sum[AW-1:0];
        e.size = rs_size[p*2 +: 2];
        e.mis  = exp_mis(e.size, e.addr);
        return e;
    endfunction

    task automatic model_clear();
        q.delete();
        s1_v = 1'b0;
        rr   = 0;
    endtask

    // Compare outputs against the model, then advance the model by one edge.
    task automatic model_cycle();
        bit pop;
        int used;
        int g;
        logic [NP-1:0] exp_rdy;
        pop     = (q.size() > 0) && lsq_ready && !flush;
        used    = q.size() + int'(s1_v) - int'(pop);
        g       = -1;
        exp_rdy = '0;
        if (!flush && used < DEPTH) begin
            for (int k = 0; k < NP; k++) begin
                int p;
                p = (rr + k) % NP;
                if (g < 0 && rs_valid[p]) g = p;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        check_eq("rs_ready", rs_ready, exp_rdy);
        check_eq("lsq_valid", lsq_valid, q.size() != 0);
        if (q.size() != 0) begin
            check_eq("lsq_tag", lsq_tag, q[0].tag);
            check_eq("lsq_data", lsq_data, q[0].data);
            check_eq("lsq_addr", lsq_addr, q[0].addr);
            check_eq("lsq_size", lsq_size, q[0].size);
            check_eq("lsq_mis", lsq_misaligned, q[0].mis);
        end
        if (flush) begin
            q.delete();
            s1_v = 1'b0;
        end else begin
            if (pop) void'(q.pop_front());
            if (s1_v) q.push_back(s1_m);
            s1_v = (g >= 0);
            if (g >= 0) begin
                s1_m = build(g);
                rr   = (g + 1) % NP;
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    // Called at a falling edge with inputs already driven.
    task automatic run_cycle();
        #1;
        model_cycle();
        @(negedge clk);
    endtask

    task automatic set_port(input int p, input logic [TW-1:0] t, input logic [DW-1:0] b,
                            input logic [DW-1:0] i, input logic [DW-1:0] d, input logic [1:0] s);
        rs_tag[p*TW +: TW]     = t;
        rs_base[p*DW +: DW]    = b;
        rs_imm[p*DW +: DW]     = i;
        rs_st_data[p*DW +: DW] = d;
        rs_size[p*2 +: 2]      = s;
    endtask

    task automatic rand_ports();
        for (int p = 0; p < NP; p++) begin
            set_port(p, TW'($urandom), $urandom,
                     ($urandom_range(0, 1) == 0) ? $urandom : DW'($urandom_range(0, 15)),
                     $urandom, 2'($urandom));
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        flush    = 1'b0;
        rs_valid = '0;
        model_clear();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic directed(input int p, input logic [TW-1:0] t, input logic [DW-1:0] b,
                            input logic [DW-1:0] i, input logic [1:0] s,
                            input logic [AW-1:0] exp_addr, input logic exp_m);
        lsq_ready = 1'b1;
        rs_valid  = '0;
        rs_valid[p] = 1'b1;
        set_port(p, t, b, i, 32'hCAFE_0000 + DW'(t), s);
        run_cycle();
        rs_valid = '0;
        run_cycle();
        #1;
        check_eq("dir_valid", lsq_valid, 1'b1);
        check_eq("dir_addr", lsq_addr, exp_addr);
        check_eq("dir_tag", lsq_tag, t);
        check_eq("dir_mis", lsq_misaligned, exp_m);
        run_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        logic [NP-1:0] alt [6];
        reset     = 1'b1;
        flush     = 1'b0;
        lsq_ready = 1'b1;
        rs_valid  = 2'b11;
        rand_ports();
        model_clear();
        @(negedge clk);
        #1;
        check_eq("rst_rs_ready", rs_ready, 2'b00);
        check_eq("rst_lsq_valid", lsq_valid, 1'b0);
        check_eq("rst_lsq_tag", lsq_tag, 5'd0);
        check_eq("rst_lsq_addr", lsq_addr, 16'd0);
        check_eq("rst_lsq_data", lsq_data, 32'd0);
        check_eq("rst_lsq_size", lsq_size, 2'd0);
        check_eq("rst_lsq_mis", lsq_misaligned, 1'b0);
        @(negedge clk);
        reset    = 1'b0;
        rs_valid = '0;

        // Single requests: latency, wrap/truncate, misalignment flag
        directed(0, 5'd3, 32'h0000_0100, 32'h0000_0024, 2'd2, 16'h0124, 1'b0);
        directed(1, 5'd9, 32'hFFFF_FFFC, 32'h0000_0008, 2'd2, 16'h0004, 1'b0);
        directed(0, 5'd5, 32'h0000_0101, 32'h0000_0000, 2'd1, 16'h0101, MIS_ON);
        directed(0, 5'd6, 32'h0000_0101, 32'h0000_0000, 2'd0, 16'h0101, 1'b0);
        directed(1, 5'd7, 32'h0000_0102, 32'h0000_0000, 2'd3, 16'h0102, MIS_ON);

        // Both ports continuously valid: grants alternate starting at port 0
        do_reset();
        lsq_ready = 1'b1;
        rs_valid  = 2'b11;
        alt = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
        for (int c = 0; c < 6; c++) begin
            rand_ports();
            #1;
            check_eq("rr_alternate", rs_ready, alt[c]);
            run_cycle();
        end
        rs_valid = '0;
        repeat (4) run_cycle();

        // Stalled LSQ: exactly DEPTH requests admitted, then one per pop
        do_reset();
        lsq_ready = 1'b0;
        rs_valid  = 2'b01;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            rand_ports();
            #1;
            acc += int'(rs_ready[0]);
            run_cycle();
        end
        check_eq("stall_accepts", acc, DEPTH);
        lsq_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            rand_ports();
            run_cycle();
        end
        rs_valid = '0;
        repeat (6) run_cycle();

        // Flush with three buffered requests and stage 1 busy
        do_reset();
        lsq_ready = 1'b0;
        rs_valid  = 2'b01;
        for (int c = 0; c < 4; c++) begin
            rand_ports();
            run_cycle();
        end
        flush = 1'b1;
        #1;
        check_eq("flush_ready", rs_ready, 2'b00);
        run_cycle();
        flush = 1'b0;
        rand_ports();
        #1;
        check_eq("post_flush_valid", lsq_valid, 1'b0);
        check_eq("post_flush_ready", rs_ready, 2'b01);
        run_cycle();
        lsq_ready = 1'b1;
        rs_valid  = '0;
        repeat (4) run_cycle();

        // Randomized traffic with occasional flush and one asynchronous reset
        for (int c = 0; c < 1500; c++) begin
            rs_valid  = NP'($urandom);
            lsq_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            rand_ports();
            if (c == 700) begin
                #2;
                reset = 1'b1;
                #1;
                check_eq("async_rst_valid", lsq_valid, 1'b0);
                check_eq("async_rst_ready", rs_ready, 2'b00);
                model_clear();
                @(negedge clk);
                reset = 1'b0;
            end else begin
                run_cycle();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
